// File: rtl/sensor_arbiter.sv
// sensor_arbiter: N raw request inputs are synchronised, debounced and arbitrated
// round-robin onto a registered one-hot grant S. A fairness timer forces the current
// holder to let go once it has held S for HOLD_CYCLES cycles while others wait.
module sensor_arbiter #(
    parameter int unsigned N           = 4,
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             M,
    output logic [N-1:0]             S,
    output logic                     busy,
    output logic [$clog2(N)-1:0]     gnt_idx,
    output logic [$clog2(N+1)-1:0]   n_active
);

    localparam int unsigned IdxW  = $clog2(N);
    localparam int unsigned CntW  = $clog2(N + 1);
    localparam int unsigned DebW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [DebW-1:0]  DebMax  = DebW'(DEB_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);
    localparam logic [IdxW-1:0]  IdxLast = IdxW'(N - 1);
    localparam logic [N-1:0]     OneHot0 = {{(N - 1){1'b0}}, 1'b1};

    typedef enum logic {
        StIdle,
        StGrant
    } state_e;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [N-1:0] sync1_q;
    logic [N-1:0] m_s_q;

    // Two-flop synchroniser per channel; m_s_q is the first metastability-safe copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            m_s_q   <= '0;
        end else begin
            sync1_q <= M;
            m_s_q   <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    logic [N-1:0]    m_f_q;
    logic [N-1:0]    m_f_d;
    logic [DebW-1:0] deb_cnt_q [N];
    logic [DebW-1:0] deb_cnt_d [N];

    // Count consecutive samples disagreeing with the filtered level; accept the new
    // level on the DEB_CYCLES-th one. Any agreeing sample restarts the count.
    always_comb begin
        m_f_d = m_f_q;
        for (int i = 0; i < N; i++) begin
            deb_cnt_d[i] = '0;
            if (m_s_q[i] != m_f_q[i]) begin
                if (deb_cnt_q[i] == DebMax) begin
                    m_f_d[i] = m_s_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
                end
            end
        end
    end

    // Filtered request level and per-channel debounce counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_f_q <= '0;
            for (int i = 0; i < N; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            m_f_q <= m_f_d;
            for (int i = 0; i < N; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Active-request count
    // ------------------------------------------------------------------
    logic [CntW-1:0] n_active_q;
    logic [CntW-1:0] n_active_d;

    // Popcount of the debounced requests.
    always_comb begin
        n_active_d = '0;
        for (int i = 0; i < N; i++) begin
            n_active_d = n_active_d + CntW'(m_f_q[i]);
        end
    end

    // Registered popcount, one cycle behind m_f.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_active_q <= '0;
        end else begin
            n_active_q <= n_active_d;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [N-1:0]     s_q, s_d;
    logic [IdxW-1:0]  gnt_q, gnt_d;

    logic             pick_found;
    logic [IdxW-1:0]  pick_idx;
    logic [IdxW-1:0]  cand;
    logic             holder_req;
    logic             others_req;

    // First requesting channel scanning ptr, ptr+1, ... with wrap modulo N.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < N; k++) begin
            cand = IdxW'((int'(ptr_q) + k) % int'(N));
            if (!pick_found && m_f_q[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // s_q is the one-hot of the holder, so it doubles as the holder mask.
    always_comb begin
        holder_req = |(m_f_q & s_q);
        others_req = |(m_f_q & ~s_q);
    end

    // Next-state logic: grant from idle, release on drop-out or fairness timeout.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        s_d     = s_q;
        gnt_d   = gnt_q;
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StGrant;
                    s_d     = OneHot0 << pick_idx;
                    gnt_d   = pick_idx;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                if (!holder_req || (hold_q == HoldMax && others_req)) begin
                    // Release always passes through idle so the next grant starts clean.
                    state_d = StIdle;
                    s_d     = '0;
                    gnt_d   = '0;
                    hold_d  = '0;
                    ptr_d   = (gnt_q == IdxLast) ? '0 : gnt_q + IdxW'(1);
                end else if (hold_q != HoldMax) begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                s_d     = '0;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Arbiter state, pointer, fairness timer and registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            hold_q  <= '0;
            s_q     <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            s_q     <= s_d;
            gnt_q   <= gnt_d;
        end
    end

    assign S        = s_q;
    assign busy     = |s_q;
    assign gnt_idx  = gnt_q;
    assign n_active = n_active_q;

endmodule

// File: tb/tb_sensor_arbiter.sv
// Testbench for sensor_arbiter: directed scenarios with hand-computed expectations plus
// a long randomised run checked every cycle against a behavioural model.
module tb_sensor_arbiter;

    localparam int N = 4;
    localparam int D = 4;
    localparam int H = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] M   = '0;
    logic [N-1:0] S;
    logic         busy;
    logic [1:0]   gnt_idx;
    logic [2:0]   n_active;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    sensor_arbiter #(
        .N           (N),
        .DEB_CYCLES  (D),
        .HOLD_CYCLES (H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .M        (M),
        .S        (S),
        .busy     (busy),
        .gnt_idx  (gnt_idx),
        .n_active (n_active)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Behavioural model: raw samples travel through a two-stage delay line, each
    // channel's accepted level flips after D consecutive disagreeing samples, and the
    // grant holder is an integer (-1 = nobody).
    bit m_sync1 [N];
    bit m_sync2 [N];
    bit m_filt  [N];
    int m_run   [N];
    int m_holder = -1;
    int m_ptr    = 0;
    int m_held   = 0;
    int m_nact   = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    m_sync1[i] = 1'b0;
                    m_sync2[i] = 1'b0;
                    m_filt[i]  = 1'b0;
                    m_run[i]   = 0;
                end
                m_holder = -1;
                m_ptr    = 0;
                m_held   = 0;
                m_nact   = 0;
            end else begin
                int  nxt_holder;
                int  nxt_ptr;
                int  nxt_held;
                int  waiting;
                bit  found;
                nxt_holder = m_holder;
                nxt_ptr    = m_ptr;
                nxt_held   = m_held;
                if (m_holder < 0) begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        int c;
                        c = (m_ptr + k) % N;
                        if (!found && m_filt[c]) begin
                            found      = 1'b1;
                            nxt_holder = c;
                            nxt_held   = 0;
                        end
                    end
                end else begin
                    waiting = 0;
                    for (int i = 0; i < N; i++) begin
                        if (i != m_holder && m_filt[i]) waiting++;
                    end
                    if (!m_filt[m_holder] || (m_held >= H - 1 && waiting > 0)) begin
                        nxt_holder = -1;
                        nxt_ptr    = (m_holder + 1) % N;
                        nxt_held   = 0;
                    end else if (m_held < H - 1) begin
                        nxt_held = m_held + 1;
                    end
                end
                m_nact = 0;
                for (int i = 0; i < N; i++) m_nact += int'(m_filt[i]);
                for (int i = 0; i < N; i++) begin
                    if (m_sync2[i] == m_filt[i]) begin
                        m_run[i] = 0;
                    end else if (m_run[i] + 1 >= D) begin
                        m_filt[i] = m_sync2[i];
                        m_run[i]  = 0;
                    end else begin
                        m_run[i] = m_run[i] + 1;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    m_sync2[i] = m_sync1[i];
                    m_sync1[i] = M[i];
                end
                m_holder = nxt_holder;
                m_ptr    = nxt_ptr;
                m_held   = nxt_held;
            end
        end
    end

    // Every-cycle comparison of the DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                int exp_s;
                exp_s = (m_holder < 0) ? 0 : (1 << m_holder);
                check("model S", 32'(S), 32'(exp_s));
                check("model busy", 32'(busy), (m_holder < 0) ? 32'd0 : 32'd1);
                check("model gnt_idx", 32'(gnt_idx), (m_holder < 0) ? 32'd0 : 32'(m_holder));
                check("model n_active", 32'(n_active), 32'(m_nact));
            end
        end
    end

    initial begin
        // Reset held two cycles with all inputs asserted.
        rst = 1'b1;
        M   = 4'b1111;
        for (int t = 0; t < 2; t++) begin
            tick();
            chk_en = 1'b1;
            check("reset S", 32'(S), 32'd0);
            check("reset busy", 32'(busy), 32'd0);
            check("reset gnt_idx", 32'(gnt_idx), 32'd0);
            check("reset n_active", 32'(n_active), 32'd0);
        end
        rst = 1'b0;
        M   = 4'b0000;
        tick();

        // Three-cycle glitch on channel 0 must be filtered out.
        M = 4'b0001;
        repeat (3) tick();
        M = 4'b0000;
        for (int t = 0; t < 10; t++) begin
            tick();
            check("glitch S", 32'(S), 32'd0);
        end

        // Single request on channel 2: grant on the 7th edge, release 7 edges after drop.
        M = 4'b0100;
        repeat (6) tick();
        check("ch2 S before", 32'(S), 32'd0);
        check("ch2 n_active before", 32'(n_active), 32'd0);
        tick();
        check("ch2 S", 32'(S), 32'b0100);
        check("ch2 gnt_idx", 32'(gnt_idx), 32'd2);
        check("ch2 busy", 32'(busy), 32'd1);
        check("ch2 n_active", 32'(n_active), 32'd1);
        repeat (5) tick();
        M = 4'b0000;
        repeat (6) tick();
        check("ch2 S held", 32'(S), 32'b0100);
        tick();
        check("ch2 S released", 32'(S), 32'd0);
        check("ch2 busy released", 32'(busy), 32'd0);

        // Two contenders: 8-cycle slices separated by one idle cycle.
        M = 4'b0011;
        for (int t = 1; t <= 25; t++) begin
            int e;
            tick();
            e = (t < 7) ? 0 : (t <= 14) ? 1 : (t == 15) ? 0 : (t <= 23) ? 2 : (t == 24) ? 0 : 1;
            check("pair S", 32'(S), 32'(e));
        end
        M = 4'b0000;
        repeat (10) tick();

        // All four requesting after a reset: grants rotate from channel 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        M   = 4'b1111;
        for (int t = 1; t <= 72; t++) begin
            tick();
            if (t >= 7 && (t - 7) % 9 == 0) begin
                check("rotate S", 32'(S), 32'(1 << (((t - 7) / 9) % 4)));
                check("rotate n_active", 32'(n_active), 32'd4);
            end
        end
        check("ch3 before reset", 32'(S), 32'b1000);

        // Reset in the middle of channel 3's grant.
        rst = 1'b1;
        M   = 4'b0000;
        tick();
        check("midrst S", 32'(S), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst gnt_idx", 32'(gnt_idx), 32'd0);
        check("midrst n_active", 32'(n_active), 32'd0);
        rst = 1'b0;
        repeat (10) tick();
        M = 4'b1001;
        repeat (7) tick();
        check("post-reset ptr S", 32'(S), 32'b0001);
        check("post-reset ptr gnt_idx", 32'(gnt_idx), 32'd0);
        M = 4'b0000;
        repeat (10) tick();

        // Randomised run: slowly toggling inputs with occasional resets.
        for (int t = 0; t < 4000; t++) begin
            logic [N-1:0] flip;
            for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 19) == 0);
            M   = M ^ flip;
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
